// File: rtl/acc_pkg.sv
// Shared types for the C-interface accelerator endpoint.
// Context record kept per outstanding request.
package acc_pkg;

    localparam int AccRdLsb = 7;

    typedef struct packed {
        logic [31:0] hart_id;
        logic [4:0]  rd;
        logic        addr_err;
    } acc_ep_ctx_t;

endpackage

// File: rtl/acc_ep_ctx_fifo.sv
// In-order context FIFO for acc_c_endpoint.
// Depth must be a power of two so the pointers wrap on their own.
import acc_pkg::*;

module acc_ep_ctx_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  acc_ep_ctx_t wdata_i,
    input  logic        pop_i,
    output acc_ep_ctx_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    acc_ep_ctx_t           mem [Depth];
    logic [PtrW-1:0]       rd_ptr;
    logic [PtrW-1:0]       wr_ptr;
    logic [CntW-1:0]       count;

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign rdata_o = mem[rd_ptr];

    // Pointers and occupancy; push and pop together leave the count as is.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
            if (push_i && !pop_i)      count <= count + 1'b1;
            else if (!push_i && pop_i) count <= count - 1'b1;
        end
    end

    // Storage; a full push+pop overwrites the slot being read out this cycle.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/acc_c_endpoint.sv
// Accelerator-side C responder: forwards requests to a datapath, merges results with context.
// Define ACC_C_ENDPOINT_RSP_REG_EN to put a 2-entry spill register on the response path.
import acc_pkg::*;

module acc_c_endpoint #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 4,
    parameter int CtxDepth  = 4,
    parameter int AccAddr   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   c_q_valid_i,
    output logic                   c_q_ready_o,
    input  logic [AddrWidth-1:0]   c_q_addr_i,
    input  logic [31:0]            c_q_instr_data_i,
    input  logic [3*DataWidth-1:0] c_q_rs_i,
    input  logic [31:0]            c_q_hart_id_i,
    output logic                   c_p_valid_o,
    input  logic                   c_p_ready_i,
    output logic [2*DataWidth-1:0] c_p_data_o,
    output logic                   c_p_dual_wb_o,
    output logic [4:0]             c_p_rd_o,
    output logic                   c_p_error_o,
    output logic [31:0]            c_p_hart_id_o,
    output logic                   op_valid_o,
    input  logic                   op_ready_i,
    output logic [31:0]            op_instr_o,
    output logic [3*DataWidth-1:0] op_rs_o,
    input  logic                   res_valid_i,
    output logic                   res_ready_o,
    input  logic [2*DataWidth-1:0] res_data_i,
    input  logic                   res_dual_wb_i,
    input  logic                   res_error_i,
    output logic                   overflow_o
);

    localparam int RspW = 2 * DataWidth + 39;

    logic            active;
    logic            ctx_full;
    logic            ctx_empty;
    logic            ctx_push;
    logic            ctx_pop;
    logic            room;
    acc_ep_ctx_t     ctx_wdata;
    acc_ep_ctx_t     ctx_head;
    logic [RspW-1:0] rsp_in;
    logic            overflow_q;

    // Holds every handshake low while in reset and for the first cycle after.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) active <= 1'b0;
        else         active <= 1'b1;
    end

    // A pop in the same cycle frees a slot for the incoming request.
    assign room        = !ctx_full || ctx_pop;
    assign op_valid_o  = active && c_q_valid_i && room;
    assign c_q_ready_o = active && op_ready_i && room;
    assign op_instr_o  = active ? c_q_instr_data_i : '0;
    assign op_rs_o     = active ? c_q_rs_i : '0;
    assign ctx_push    = c_q_valid_i && c_q_ready_o;

    assign ctx_wdata = '{
        hart_id:  c_q_hart_id_i,
        rd:       c_q_instr_data_i[AccRdLsb +: 5],
        addr_err: (c_q_addr_i != AddrWidth'(AccAddr))
    };

    acc_ep_ctx_fifo #(
        .Depth (CtxDepth)
    ) u_ctx (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ctx_push),
        .wdata_i (ctx_wdata),
        .pop_i   (ctx_pop),
        .rdata_o (ctx_head),
        .full_o  (ctx_full),
        .empty_o (ctx_empty)
    );

    assign rsp_in = {res_data_i, res_dual_wb_i, ctx_head.rd,
                     res_error_i | ctx_head.addr_err, ctx_head.hart_id};

`ifdef ACC_C_ENDPOINT_RSP_REG_EN
    logic [RspW-1:0] sp_mem [2];
    logic            sp_wp;
    logic            sp_rp;
    logic [1:0]      sp_cnt;
    logic            sp_pop;

    assign res_ready_o = active && !ctx_empty && (sp_cnt != 2'd2);
    assign ctx_pop     = res_valid_i && res_ready_o;
    assign c_p_valid_o = (sp_cnt != 2'd0);
    assign sp_pop      = c_p_valid_o && c_p_ready_i;

    assign {c_p_data_o, c_p_dual_wb_o, c_p_rd_o, c_p_error_o, c_p_hart_id_o} =
        c_p_valid_o ? sp_mem[sp_rp] : '0;

    // Two-slot response buffer: accepts a result while the consumer drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_mem[0] <= '0;
            sp_mem[1] <= '0;
            sp_wp     <= 1'b0;
            sp_rp     <= 1'b0;
            sp_cnt    <= 2'd0;
        end else begin
            if (ctx_pop) begin
                sp_mem[sp_wp] <= rsp_in;
                sp_wp         <= ~sp_wp;
            end
            if (sp_pop) sp_rp <= ~sp_rp;
            if (ctx_pop && !sp_pop)      sp_cnt <= sp_cnt + 2'd1;
            else if (!ctx_pop && sp_pop) sp_cnt <= sp_cnt - 2'd1;
        end
    end
`else
    assign c_p_valid_o = active && res_valid_i && !ctx_empty;
    assign res_ready_o = active && c_p_ready_i && !ctx_empty;
    assign ctx_pop     = c_p_valid_o && c_p_ready_i;

    assign {c_p_data_o, c_p_dual_wb_o, c_p_rd_o, c_p_error_o, c_p_hart_id_o} =
        c_p_valid_o ? rsp_in : '0;
`endif

    // Sticky flag for a result that arrives with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                 overflow_q <= 1'b0;
        else if (active && res_valid_i && ctx_empty) overflow_q <= 1'b1;
    end

    assign overflow_o = overflow_q;

    a_no_orphan_result : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(active && res_valid_i && ctx_empty)
    ) else $warning("acc_c_endpoint: result with no outstanding context");

endmodule

// File: tb/tb_acc_c_endpoint.sv
// Self-checking bench for acc_c_endpoint: vector table, directed corners, random scoreboard.
// Works with or without ACC_C_ENDPOINT_RSP_REG_EN.
module tb_acc_c_endpoint;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int D  = 4;
    localparam int AA = 0;
`ifdef ACC_C_ENDPOINT_RSP_REG_EN
    localparam int RspLat = 1;
`else
    localparam int RspLat = 0;
`endif

    typedef struct packed {
        logic [63:0] data;
        logic        dual;
        logic [4:0]  rd;
        logic        err;
        logic [31:0] hart;
    } rsp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] instr;
        logic [95:0] rs;
        logic [31:0] hart;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic        dual;
        logic        err;
    } res_t;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [95:0] rs;
        logic        opr;
        logic        e_opv;
        logic        e_qr;
    } vec_t;

    logic clk;
    logic rst_ni;
    logic c_q_valid_i, c_q_ready_o;
    logic [AW-1:0] c_q_addr_i;
    logic [31:0] c_q_instr_data_i;
    logic [3*DW-1:0] c_q_rs_i;
    logic [31:0] c_q_hart_id_i;
    logic c_p_valid_o, c_p_ready_i;
    logic [2*DW-1:0] c_p_data_o;
    logic c_p_dual_wb_o;
    logic [4:0] c_p_rd_o;
    logic c_p_error_o;
    logic [31:0] c_p_hart_id_o;
    logic op_valid_o, op_ready_i;
    logic [31:0] op_instr_o;
    logic [3*DW-1:0] op_rs_o;
    logic res_valid_i, res_ready_o;
    logic [2*DW-1:0] res_data_i;
    logic res_dual_wb_i, res_error_i;
    logic overflow_o;

    acc_c_endpoint #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .CtxDepth  (D),
        .AccAddr   (AA)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .c_q_valid_i      (c_q_valid_i),
        .c_q_ready_o      (c_q_ready_o),
        .c_q_addr_i       (c_q_addr_i),
        .c_q_instr_data_i (c_q_instr_data_i),
        .c_q_rs_i         (c_q_rs_i),
        .c_q_hart_id_i    (c_q_hart_id_i),
        .c_p_valid_o      (c_p_valid_o),
        .c_p_ready_i      (c_p_ready_i),
        .c_p_data_o       (c_p_data_o),
        .c_p_dual_wb_o    (c_p_dual_wb_o),
        .c_p_rd_o         (c_p_rd_o),
        .c_p_error_o      (c_p_error_o),
        .c_p_hart_id_o    (c_p_hart_id_o),
        .op_valid_o       (op_valid_o),
        .op_ready_i       (op_ready_i),
        .op_instr_o       (op_instr_o),
        .op_rs_o          (op_rs_o),
        .res_valid_i      (res_valid_i),
        .res_ready_o      (res_ready_o),
        .res_data_i       (res_data_i),
        .res_dual_wb_i    (res_dual_wb_i),
        .res_error_i      (res_error_i),
        .overflow_o       (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    req_t reqq[$];
    req_t ctxq[$];
    res_t dpq[$];
    rsp_t rspq[$];
    rsp_t got[$];
    int   pr_mode;
    int   rand_q;
    logic r_hs_last;
    logic stalled;
    rsp_t last;
    vec_t vt[6];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rsp_t cur_rsp();
        return {c_p_data_o, c_p_dual_wb_o, c_p_rd_o, c_p_error_o, c_p_hart_id_o};
    endfunction

    task automatic zero_inputs();
        c_q_valid_i = 0; c_q_addr_i = '0; c_q_instr_data_i = '0;
        c_q_rs_i = '0; c_q_hart_id_i = '0; c_p_ready_i = 0;
        op_ready_i = 0; res_valid_i = 0; res_data_i = '0;
        res_dual_wb_i = 0; res_error_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        zero_inputs();
        reqq.delete(); ctxq.delete(); dpq.delete(); rspq.delete(); got.delete();
        r_hs_last = 0; stalled = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_ni = 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic push_req(logic [31:0] hart, logic [31:0] instr, logic [3:0] addr, logic exp);
        @(posedge clk); #1;
        c_q_valid_i = 1; c_q_hart_id_i = hart; c_q_instr_data_i = instr;
        c_q_addr_i = addr; c_q_rs_i = {3{hart}}; op_ready_i = 1;
        @(negedge clk);
        chk("push_ready", c_q_ready_o, exp);
        chk("push_opvalid", op_valid_o, exp);
    endtask

    // Caller has already driven res_* and c_p_ready_i at posedge+1.
    task automatic take_one(output rsp_t r, output int lat);
        logic hs;
        lat = -1;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (c_p_valid_o && c_p_ready_i && lat < 0) begin
                lat = k;
                r = cur_rsp();
            end
            hs = res_valid_i && res_ready_o;
            @(posedge clk); #1;
            c_q_valid_i = 0;
            if (hs) res_valid_i = 0;
        end
    endtask

    task automatic step();
        rsp_t cur;
        rsp_t e;
        res_t rr;
        req_t qq;
        logic q_hs, r_hs, p_hs;
        int n;
        @(posedge clk); #1;
        if (reqq.size() > 0 && (rand_q == 0 || $urandom_range(3) != 0)) begin
            c_q_valid_i = 1;
            c_q_addr_i = reqq[0].addr;
            c_q_instr_data_i = reqq[0].instr;
            c_q_rs_i = reqq[0].rs;
            c_q_hart_id_i = reqq[0].hart;
        end else begin
            c_q_valid_i = 0;
        end
        op_ready_i = (rand_q == 0) ? 1'b1 : ($urandom_range(3) != 0);
        if (r_hs_last) res_valid_i = 0;
        if (!res_valid_i && dpq.size() > 0 && (rand_q == 0 || $urandom_range(1) == 0)) begin
            res_valid_i = 1;
            res_data_i = dpq[0].data;
            res_dual_wb_i = dpq[0].dual;
            res_error_i = dpq[0].err;
        end
        case (pr_mode)
            0: c_p_ready_i = 1;
            1: c_p_ready_i = ~c_p_ready_i;
            default: c_p_ready_i = ($urandom_range(1) != 0);
        endcase
        @(negedge clk);
        cur = cur_rsp();
        q_hs = c_q_valid_i && c_q_ready_o;
        r_hs = res_valid_i && res_ready_o;
        p_hs = c_p_valid_o && c_p_ready_i;
        n = ctxq.size();
`ifndef ACC_C_ENDPOINT_RSP_REG_EN
        begin
            logic pop_e;
            pop_e = res_valid_i && c_p_ready_i && n > 0;
            chk("q_ready", c_q_ready_o, op_ready_i && (n < D || pop_e));
            chk("op_valid", op_valid_o, c_q_valid_i && (n < D || pop_e));
            chk("p_valid", c_p_valid_o, res_valid_i && n > 0);
            chk("res_ready", res_ready_o, c_p_ready_i && n > 0);
        end
`endif
        if (stalled) begin
            chk("stall_valid", c_p_valid_o, 1'b1);
            chk("stall_payload", cur, last);
        end
        stalled = c_p_valid_o && !c_p_ready_i;
        last = cur;
        if (q_hs) begin
            chk("op_instr", op_instr_o, reqq[0].instr);
            chk("op_rs", op_rs_o, reqq[0].rs);
            ctxq.push_back(reqq.pop_front());
            rr.data = {$urandom, $urandom};
            rr.dual = $urandom_range(1);
            rr.err = (rand_q != 0) && ($urandom_range(7) == 0);
            dpq.push_back(rr);
        end
        if (r_hs) begin
            rr = dpq.pop_front();
            qq = ctxq.pop_front();
            e.data = rr.data;
            e.dual = rr.dual;
            e.rd = qq.instr[11:7];
            e.err = rr.err | (qq.addr != 4'(AA));
            e.hart = qq.hart;
            rspq.push_back(e);
        end
        if (p_hs) begin
            got.push_back(cur);
            if (rspq.size() == 0) chk("p_unexpected", 1'b1, 1'b0);
            else chk("rsp", cur, rspq.pop_front());
        end
        r_hs_last = r_hs;
    endtask

    task automatic run_seq(int maxc);
        logic done;
        done = 0;
        for (int c = 0; c < maxc && !done; c++) begin
            step();
            done = reqq.size() == 0 && ctxq.size() == 0 &&
                   dpq.size() == 0 && rspq.size() == 0;
        end
        chk("drain", done, 1'b1);
        @(posedge clk); #1;
        zero_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t r;
        int lat;
        req_t q;

        vt[0] = '{v:0, instr:32'h0000_0013, rs:96'h1, opr:0, e_opv:0, e_qr:0};
        vt[1] = '{v:1, instr:32'h0000_0093, rs:96'h2, opr:0, e_opv:1, e_qr:0};
        vt[2] = '{v:0, instr:32'h0000_0113, rs:96'h3, opr:1, e_opv:0, e_qr:1};
        vt[3] = '{v:1, instr:32'h1234_5678, rs:96'h4, opr:1, e_opv:1, e_qr:1};
        vt[4] = '{v:1, instr:32'hFFFF_FFFF, rs:{96{1'b1}}, opr:1, e_opv:1, e_qr:1};
        vt[5] = '{v:0, instr:32'h0, rs:96'h0, opr:0, e_opv:0, e_qr:0};

        // Reset values with every input pushing towards a handshake.
        rst_ni = 0;
        zero_inputs();
        c_q_valid_i = 1; op_ready_i = 1; res_valid_i = 1; c_p_ready_i = 1;
        c_q_instr_data_i = 32'hDEAD_BEEF; res_data_i = 64'h55;
        #12;
        chk("rst_q_ready", c_q_ready_o, 1'b0);
        chk("rst_op_valid", op_valid_o, 1'b0);
        chk("rst_p_valid", c_p_valid_o, 1'b0);
        chk("rst_res_ready", res_ready_o, 1'b0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_p_data", c_p_data_o, 64'h0);
        chk("rst_op_instr", op_instr_o, 32'h0);
        do_reset();

        // Request-path vectors with an empty context FIFO.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            c_q_valid_i = vt[i].v; c_q_instr_data_i = vt[i].instr;
            c_q_rs_i = vt[i].rs; op_ready_i = vt[i].opr;
            #3;
            chk("vec_op_valid", op_valid_o, vt[i].e_opv);
            chk("vec_q_ready", c_q_ready_o, vt[i].e_qr);
            chk("vec_op_instr", op_instr_o, vt[i].instr);
            chk("vec_op_rs", op_rs_o, vt[i].rs);
            c_q_valid_i = 0;
        end

        // Single op.
        push_req(32'hCAFE_CAFE, 32'h00A5_80B3, 4'(AA), 1'b1);
        @(posedge clk); #1;
        c_q_valid_i = 0;
        res_valid_i = 1; res_data_i = 64'h1234; res_dual_wb_i = 0; res_error_i = 0;
        c_p_ready_i = 1;
        take_one(r, lat);
        chk("single_lat", lat, RspLat);
        chk("single_data", r.data, 64'h1234);
        chk("single_rd", r.rd, 5'd1);
        chk("single_hart", r.hart, 32'hCAFE_CAFE);
        chk("single_err", r.err, 1'b0);
        chk("single_idle", c_p_valid_o, 1'b0);
        do_reset();

        // Fill to CtxDepth, then pop and accept in one cycle.
        for (int i = 0; i < D; i++)
            push_req(i, (i + 1) << 7, 4'(AA), 1'b1);
        push_req(32'd4, 32'd5 << 7, 4'(AA), 1'b0);
        @(posedge clk); #1;
        res_valid_i = 1; res_data_i = 64'hAA; c_p_ready_i = 1;
        #2;
        chk("fill_pop_accept", c_q_ready_o, 1'b1);
        take_one(r, lat);
        chk("fill_lat", lat, RspLat);
        chk("fill_hart", r.hart, 32'd0);
        chk("fill_rd", r.rd, 5'd1);
        do_reset();

        // Reset with three outstanding.
        for (int i = 0; i < 3; i++)
            push_req(32'h50 + i, 32'h0000_0033 | ((i + 1) << 7), 4'(AA), 1'b1);
        @(posedge clk); #1;
        res_valid_i = 1; c_p_ready_i = 1; c_q_valid_i = 1;
        #1 rst_ni = 0;
        #1;
        chk("midrst_p_valid", c_p_valid_o, 1'b0);
        chk("midrst_op_valid", op_valid_o, 1'b0);
        chk("midrst_q_ready", c_q_ready_o, 1'b0);
        chk("midrst_res_ready", res_ready_o, 1'b0);
        zero_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_ni = 1;
        repeat (2) @(posedge clk);

        // Result with empty FIFO: not accepted, sticky overflow.
        #1;
        res_valid_i = 1; res_data_i = 64'h77; c_p_ready_i = 1;
        @(negedge clk);
        chk("ovf_res_ready", res_ready_o, 1'b0);
        chk("ovf_p_valid", c_p_valid_o, 1'b0);
        chk("ovf_pre", overflow_o, 1'b0);
        @(negedge clk);
        chk("ovf_set", overflow_o, 1'b1);
        res_valid_i = 0;
        repeat (2) @(negedge clk);
        chk("ovf_held", overflow_o, 1'b1);
        rst_ni = 0;
        #1;
        chk("ovf_cleared", overflow_o, 1'b0);
        do_reset();

        // Order and backpressure, one address mismatch on rd=4.
        pr_mode = 1;
        rand_q = 0;
        for (int i = 1; i <= 8; i++) begin
            q.addr = (i == 4) ? 4'(AA + 1) : 4'(AA);
            q.instr = 32'h0000_0033 | (i << 7);
            q.rs = {$urandom, $urandom, $urandom};
            q.hart = 32'h100 + i;
            reqq.push_back(q);
        end
        run_seq(200);
        chk("order_count", got.size(), 8);
        if (got.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk("order_rd", got[i].rd, 5'(i + 1));
            chk("mm_err_prev", got[2].err, 1'b0);
            chk("mm_err", got[3].err, 1'b1);
            chk("mm_err_next", got[4].err, 1'b0);
        end
        do_reset();

        // Randomized traffic against the scoreboard.
        pr_mode = 2;
        rand_q = 1;
        for (int i = 0; i < 200; i++) begin
            q.addr = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'(AA);
            q.instr = $urandom;
            q.rs = {$urandom, $urandom, $urandom};
            q.hart = $urandom;
            reqq.push_back(q);
        end
        run_seq(4000);
        chk("rand_count", got.size(), 200);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
